// File: rtl/sobel_window.sv
// Line-buffered 3x3 window generator feeding the Sobel kernel.
// Emits one window per interior pixel of a raster-order 8-bit stream.
module sobel_window #(
    parameter int IMG_W = 352,
    parameter int IMG_H = 288,
    parameter int XW    = 9,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    s11,
    output logic [7:0]    s12,
    output logic [7:0]    s13,
    output logic [7:0]    s21,
    output logic [7:0]    s22,
    output logic [7:0]    s23,
    output logic [7:0]    s31,
    output logic [7:0]    s32,
    output logic [7:0]    s33,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          frame_done
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    // Two most recent window columns, each {row1, row2, row3}
    logic [7:0]    r_c1_t, r_c1_m, r_c1_b;
    logic [7:0]    r_c2_t, r_c2_m, r_c2_b;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_win_done;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_tap_a;
    logic [7:0]    w_tap_b;

    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == XW'(IMG_W - 1));
    assign w_row_last = (r_row == YW'(IMG_H - 1));
    assign w_win_done = w_accept && (r_row >= YW'(2)) && (r_col >= XW'(2));
    assign w_idx      = r_col[AW-1:0];
    assign w_tap_a    = r_lb1[w_idx];
    assign w_tap_b    = r_lb0[w_idx];

    // Line buffers carry no reset: every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_idx] <= r_lb0[w_idx];
            r_lb0[w_idx] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + YW'(1);
                end else begin
                    r_col <= r_col + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c1_t <= '0; r_c1_m <= '0; r_c1_b <= '0;
            r_c2_t <= '0; r_c2_m <= '0; r_c2_b <= '0;
        end else if (w_accept) begin
            r_c1_t <= r_c2_t;  r_c1_m <= r_c2_m;  r_c1_b <= r_c2_b;
            r_c2_t <= w_tap_a; r_c2_m <= w_tap_b; r_c2_b <= in_pixel;
        end
    end

    // Output register doubles as the one-deep skid; only reloaded when a window completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            s11 <= '0; s12 <= '0; s13 <= '0;
            s21 <= '0; s22 <= '0; s23 <= '0;
            s31 <= '0; s32 <= '0; s33 <= '0;
            out_x <= '0;
            out_y <= '0;
        end else if (w_win_done) begin
            out_valid <= 1'b1;
            s11 <= r_c1_t; s12 <= r_c2_t; s13 <= w_tap_a;
            s21 <= r_c1_m; s22 <= r_c2_m; s23 <= w_tap_b;
            s31 <= r_c1_b; s32 <= r_c2_b; s33 <= in_pixel;
            out_x <= r_col - XW'(1);
            out_y <= r_row - YW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_window.sv
// Randomized scoreboard bench for sobel_window: a whole-image reference model
// predicts every window, a monitor checks outputs, handshake, hold and frame_done.
module tb_sobel_window;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int XW = 3;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [7:0]    in_pixel;
    logic [7:0]    s11, s12, s13, s21, s22, s23, s31, s32, s33;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;

    sobel_window #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .s11(s11), .s12(s12), .s13(s13),
        .s21(s21), .s22(s22), .s23(s23),
        .s31(s31), .s32(s32), .s33(s33),
        .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0]   win;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] img [H][W];
    int         mr = 0, mc = 0, accepts = 0;
    logic       fd_next = 1'b0, fd_exp = 1'b0;
    logic       mon_en = 1'b0;

    function automatic logic [71:0] dut_win();
        return {s11, s12, s13, s21, s22, s23, s31, s32, s33};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: store the frame as an image and cut windows straight out of it.
    task automatic model_accept(input logic [7:0] p);
        exp_t e;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            e.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                     img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                     img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
            e.x = XW'(mc - 1);
            e.y = YW'(mr - 1);
            q.push_back(e);
        end
        fd_next = (mr == H - 1) && (mc == W - 1);
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        accepts++;
    endtask

    task automatic cycle(input int pv, input int pr);
        @(negedge clk);
        fd_exp    = fd_next;
        fd_next   = 1'b0;
        in_valid  = ($urandom_range(99) < pv);
        in_pixel  = 8'($urandom);
        out_ready = ($urandom_range(99) < pr);
        #2;
        if (in_valid && in_ready) model_accept(in_pixel);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        fd_exp    = fd_next;
        fd_next   = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q.delete();
        mr = 0;
        mc = 0;
        repeat (n - 1) begin
            @(negedge clk);
            fd_exp = 1'b0;
        end
        @(negedge clk);
        fd_exp    = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset out_valid", 80'(out_valid), 80'(0));
        check("reset frame_done", 80'(frame_done), 80'(0));
        check("reset window", 80'(dut_win()), 80'(0));
        check("reset coord", 80'({out_x, out_y}), 80'(0));
    endtask

    task automatic run_pixels(input int n, input int pv, input int pr);
        int target = accepts + n;
        int budget = n * 20 + 50;
        while (accepts < target && budget > 0) begin
            cycle(pv, pr);
            budget--;
        end
        check("pixel budget", 80'(accepts), 80'(target));
    endtask

    initial begin : monitor
        logic        prev_hold = 1'b0;
        logic [79:0] snap = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                check("in_ready", 80'(in_ready), 80'(!out_valid || out_ready));
                check("frame_done", 80'(frame_done), 80'(fd_exp));
                if (prev_hold)
                    check("hold", {dut_win(), out_x, out_y, out_valid}, snap);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected window", 80'(out_valid), 80'(0));
                    end else begin
                        e = q.pop_front();
                        check("window", 80'(dut_win()), 80'(e.win));
                        check("coord", 80'({out_x, out_y}), 80'({e.x, e.y}));
                    end
                end
                prev_hold = out_valid && !out_ready && !reset;
                snap = {dut_win(), out_x, out_y, out_valid};
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pixel  = 8'd0;
        do_reset(3);
        mon_en = 1'b1;
        run_pixels(3 * W * H, 100, 100);
        run_pixels(4 * W * H, 50, 70);
        run_pixels(2 * W + 3, 100, 100);
        do_reset(1);
        run_pixels(2 * W * H, 70, 50);
        run_pixels(W * H, 100, 30);
        repeat (10) cycle(0, 100);
        check("windows outstanding", 80'(q.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
